// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bus of the SR flag arbiter.
//   REQ   : one request bit per requester, held until its grant
//   OP    : 2-bit opcode per requester (00 READ, 01 CLR, 10 SET, 11 TAS)
//   IDX   : FW-bit flag index per requester
//   GNT   : one-hot, one-cycle grant
//   RDATA : pre-operation Q of the addressed flag, valid with GNT
//   ERR   : pulses with GNT when the index is out of range
// master = requester side, slave = arbiter side.
interface sr_flag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int FW   = 3
);
  logic [NREQ-1:0]    REQ;
  logic [2*NREQ-1:0]  OP;
  logic [FW*NREQ-1:0] IDX;
  logic [NREQ-1:0]    GNT;
  logic               RDATA;
  logic               ERR;

  modport master (output REQ, OP, IDX, input GNT, RDATA, ERR);
  modport slave  (input REQ, OP, IDX, output GNT, RDATA, ERR);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising READ/CLR/SET/TAS operations onto an
// external bank of NFLAG synchronous-reset SR flags.
//   CLK, RST : clock, synchronous active-high reset (shared with the bank)
//   bus      : requester bus (REQ/OP/IDX in, GNT/RDATA/ERR out)
//   Q        : flag bank outputs
//   S, R     : flag bank set/reset strobes, never both high for any flag
//   BUSY     : high while an operation is in flight
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; winner picked and strobes loaded here
// DRIVE  | GNT/S/R/RDATA/ERR presented; bank captures strobe at exit
// SETTLE | strobes released; Q now shows the result of the operation
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int FW    = 3
) (
  input  logic               CLK,
  input  logic               RST,
  sr_flag_arbiter_if.slave   bus,
  input  logic [NFLAG-1:0]   Q,
  output logic [NFLAG-1:0]   S,
  output logic [NFLAG-1:0]   R,
  output logic               BUSY
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TAS = 2'b11;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win_q;

  logic [PW-1:0] win_id;
  logic [1:0]    win_op;
  logic [FW-1:0] win_idx;
  logic          idx_ok;

  // First requester at or after ptr, wrapping. Scanning from the far end
  // down lets the nearest hit overwrite earlier ones.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [PW-1:0]   p);
    logic [PW-1:0] pick;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j = (int'(p) + k) % NREQ;
      if (req[j]) pick = PW'(j);
    end
    return pick;
  endfunction

  always_comb begin
    win_id  = rr_pick(bus.REQ, ptr);
    win_op  = bus.OP[int'(win_id) * 2 +: 2];
    win_idx = bus.IDX[int'(win_id) * FW +: FW];
    idx_ok  = (int'(win_idx) < NFLAG);
  end

  // The winner's opcode and index are consumed at the IDLE->DRIVE edge,
  // where all DRIVE outputs are loaded, so only the winner id is retained
  // (for the pointer update).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      win_q     <= '0;
      S         <= '0;
      R         <= '0;
      bus.GNT   <= '0;
      bus.RDATA <= 1'b0;
      bus.ERR   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.REQ) begin
            state   <= DRIVE;
            BUSY    <= 1'b1;
            win_q   <= win_id;
            bus.GNT <= NREQ'(1) << win_id;
            if (idx_ok) begin
              bus.RDATA <= Q[win_idx];
              bus.ERR   <= 1'b0;
              S <= (win_op == OP_SET || win_op == OP_TAS) ? (NFLAG'(1) << win_idx) : '0;
              R <= (win_op == OP_CLR) ? (NFLAG'(1) << win_idx) : '0;
            end else begin
              bus.RDATA <= 1'b0;
              bus.ERR   <= 1'b1;
              S         <= '0;
              R         <= '0;
            end
          end
        end
        DRIVE: begin
          state     <= SETTLE;
          bus.GNT   <= '0;
          bus.RDATA <= 1'b0;
          bus.ERR   <= 1'b0;
          S         <= '0;
          R         <= '0;
          ptr       <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
        end
        SETTLE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter with a behavioural SR flag bank.
module tb_sr_flag_arbiter;
  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int FW    = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NFLAG-1:0] Q;
  logic [NFLAG-1:0] S;
  logic [NFLAG-1:0] R;
  logic             BUSY;

  sr_flag_arbiter_if #(.NREQ(NREQ), .FW(FW)) bus ();

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .FW(FW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .Q   (Q),
    .S   (S),
    .R   (R),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // flag bank: synchronous reset, S/R never both high by construction
  always @(posedge CLK) begin
    if (RST) Q <= '0;
    else     Q <= (Q | S) & ~R;
  end

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic             rdata;
    logic             err;
    logic [NFLAG-1:0] s;
    logic [NFLAG-1:0] r;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   g_cyc = 0;
  int   prev_cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_pkt(input logic [NREQ-1:0] g, input logic rd, input logic e,
                            input logic [NFLAG-1:0] s, input logic [NFLAG-1:0] r);
    exp_q.push_back('{gnt: g, rdata: rd, err: e, s: s, r: r});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [FW-1:0] idx);
    bus.OP[2*i +: 2]   = op;
    bus.IDX[FW*i +: FW] = idx;
  endtask

  // Waits (bounded) for a grant cycle; optionally steps past its ending edge.
  task automatic wait_grant(input bit do_tick);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge CLK);
      if (bus.GNT != 0) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL grant_timeout: got no GNT expected a GNT within 12 cycles");
    end
    g_cyc = cyc;
    if (do_tick) tick();
  endtask

  // monitor: every grant cycle pops one expected packet
  always @(negedge CLK) begin
    if (bus.GNT != 0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: got GNT=%b expected no grant", bus.GNT);
      end else begin
        mon_e = exp_q.pop_front();
        check("gnt",        32'(bus.GNT),   32'(mon_e.gnt));
        check("rdata",      32'(bus.RDATA), 32'(mon_e.rdata));
        check("err",        32'(bus.ERR),   32'(mon_e.err));
        check("s_strobe",   32'(S),         32'(mon_e.s));
        check("r_strobe",   32'(R),         32'(mon_e.r));
        check("busy_drive", 32'(BUSY),      32'd1);
      end
    end
  end

  // invariants on every cycle
  always @(negedge CLK) begin
    check("s_and_r_zero",   32'(S & R),                          32'd0);
    check("gnt_onehot0",    32'($onehot0(bus.GNT)),              32'd1);
    check("strobe_onehot0", 32'($onehot0(S | R)),                32'd1);
    check("err_only_w_gnt", 32'(bus.ERR && (bus.GNT == 0)),      32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with every requester asking
    RST = 1'b1;
    bus.REQ = 4'b1111;
    bus.OP  = '0;
    bus.IDX = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_s",    32'(S),       32'd0);
    check("rst_r",    32'(R),       32'd0);
    check("rst_gnt",  32'(bus.GNT), 32'd0);
    check("rst_busy", 32'(BUSY),    32'd0);
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b000000, 6'b000000);
    tick();
    RST = 1'b0;
    wait_grant(1'b1);
    bus.REQ = '0;

    // single SET from requester 2 on flag 5
    set_req(2, 2'b10, 3'd5);
    bus.REQ = 4'b0100;
    expect_pkt(4'b0100, 1'b0, 1'b0, 6'b100000, 6'b000000);
    wait_grant(1'b1);
    bus.REQ = '0;
    check("set_busy_settle", 32'(BUSY), 32'd1);
    check("set_q5",          32'(Q[5]), 32'd1);
    tick();
    check("set_busy_idle",   32'(BUSY), 32'd0);

    // round-robin from a fresh pointer
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_q_cleared", 32'(Q), 32'd0);
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, FW'(i));
    bus.REQ = 4'b1111;
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b0, 6'b0);
    expect_pkt(4'b0010, 1'b0, 1'b0, 6'b0, 6'b0);
    expect_pkt(4'b0100, 1'b0, 1'b0, 6'b0, 6'b0);
    expect_pkt(4'b1000, 1'b0, 1'b0, 6'b0, 6'b0);
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b0, 6'b0);
    wait_grant(1'b1);
    for (int i = 1; i < 5; i++) begin
      prev_cyc = g_cyc;
      wait_grant(1'b1);
      check("rr_spacing", 32'(g_cyc - prev_cyc), 32'd3);
    end
    bus.REQ = '0;

    // requester 3 READ moves the pointer back to 0
    set_req(3, 2'b00, 3'd5);
    bus.REQ = 4'b1000;
    expect_pkt(4'b1000, 1'b0, 1'b0, 6'b0, 6'b0);
    wait_grant(1'b1);
    bus.REQ = '0;

    // TAS contention on flag 2
    set_req(0, 2'b11, 3'd2);
    set_req(1, 2'b11, 3'd2);
    bus.REQ = 4'b0011;
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b000100, 6'b000000);
    expect_pkt(4'b0010, 1'b1, 1'b0, 6'b000100, 6'b000000);
    wait_grant(1'b1);
    bus.REQ[0] = 1'b0;
    prev_cyc = g_cyc;
    wait_grant(1'b1);
    bus.REQ = '0;
    check("tas_spacing", 32'(g_cyc - prev_cyc), 32'd3);
    check("tas_q2",      32'(Q[2]),             32'd1);

    // CLR flag 2, then out-of-range SET
    set_req(3, 2'b01, 3'd2);
    bus.REQ = 4'b1000;
    expect_pkt(4'b1000, 1'b1, 1'b0, 6'b000000, 6'b000100);
    wait_grant(1'b1);
    check("clr_q2", 32'(Q[2]), 32'd0);
    set_req(3, 2'b10, 3'd7);
    expect_pkt(4'b1000, 1'b0, 1'b1, 6'b000000, 6'b000000);
    wait_grant(1'b1);
    bus.REQ = '0;
    check("err_q_unchanged", 32'(Q), 32'd0);

    // reset during DRIVE of a SET
    set_req(0, 2'b10, 3'd1);
    bus.REQ = 4'b0001;
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b000010, 6'b000000);
    wait_grant(1'b0);
    #1;
    RST = 1'b1;
    tick();
    check("midrst_gnt",   32'(bus.GNT),   32'd0);
    check("midrst_s",     32'(S),         32'd0);
    check("midrst_r",     32'(R),         32'd0);
    check("midrst_busy",  32'(BUSY),      32'd0);
    check("midrst_err",   32'(bus.ERR),   32'd0);
    check("midrst_rdata", 32'(bus.RDATA), 32'd0);
    check("midrst_q",     32'(Q),         32'd0);
    RST = 1'b0;
    bus.OP  = '0;
    bus.IDX = '0;
    bus.REQ = 4'b0011;
    expect_pkt(4'b0001, 1'b0, 1'b0, 6'b0, 6'b0);
    wait_grant(1'b1);
    bus.REQ = '0;

    repeat (4) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Arbitrates several requesters for shared access to an external bank of NFLAG SR flip-flops.
- Each flop is a synchronous-reset SR flag with Q/Qbar outputs; the bank shares CLK and RST with this block.
- Serialises set, clear, read and test-and-set operations, one operation at a time, with round-robin fairness.
- Guarantees that S and R are never driven high together, so the flops never enter the illegal 11 state.

Parameters:
- NREQ, 4, number of requesters.
- NFLAG, 6, number of SR flags in the bank.
- FW, 3, flag index width; must satisfy 2^FW >= NFLAG.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- REQ  in  NREQ  request per requester; held until its GNT.
- OP  in  2*NREQ  opcode of requester i at [2i+1:2i]: 00 READ, 01 CLR, 10 SET, 11 TAS (test-and-set).
- IDX  in  FW*NREQ  flag index of requester i at [FW*i+FW-1:FW*i].
- Q  in  NFLAG  Q outputs of the flag bank.
- S  out  NFLAG  set inputs to the flag bank.
- R  out  NFLAG  reset inputs to the flag bank.
- GNT  out  NREQ  one-hot, one-cycle grant.
- RDATA  out  1  pre-operation Q of the addressed flag; valid only while GNT is nonzero.
- ERR  out  1  pulses with GNT when IDX >= NFLAG.
- BUSY  out  1  high when state != IDLE.

Behaviour:
- Reset: RST is synchronous, active-high; clock CLK. RST has priority over everything.
  - Reset state: state=IDLE, PTR=0, S=0, R=0, GNT=0, RDATA=0, ERR=0, BUSY=0.
- All outputs are registered.
- FSM: IDLE -> DRIVE -> SETTLE -> IDLE.
- IDLE:
  - If any REQ bit is high, select a winner by round-robin: first set bit searching from PTR upward, wrapping at NREQ.
  - Latch the winner's id, OP and IDX, then go to DRIVE.
  - If no REQ bit is high, stay in IDLE.
- DRIVE (exactly one cycle):
  - GNT[winner]=1.
  - RDATA = Q[idx] as sampled at the IDLE->DRIVE edge (pre-update value).
  - Flag strobes for idx < NFLAG:
    - SET and TAS: S[idx]=1.
    - CLR: R[idx]=1.
    - READ: no S or R bit set.
  - If idx >= NFLAG: ERR=1, all S and R bits 0, RDATA=0.
  - PTR <= (winner+1) mod NREQ.
  - The flop captures the strobe at the DRIVE->SETTLE edge.
- SETTLE (exactly one cycle):
  - All strobes and grants are 0; Q now reflects the completed operation.
  - Go to IDLE.
  - This cycle guarantees a following TAS on the same flag sees the updated value.
- Timing:
  - REQ sampled at the edge ending IDLE cycle t gives GNT in cycle t+1; Q is updated in cycle t+2.
  - Minimum spacing between grants is 3 cycles.
- Invariants:
  - (S & R) == 0 on every cycle.
  - At most one S or R bit is high in any cycle.
  - GNT has at most one bit high.
  - ERR is high only while GNT is nonzero.
- Requesters:
  - REQ, OP and IDX must stay stable until GNT.
  - A REQ deasserted before being sampled in IDLE is simply ignored.
  - After being latched, the operation completes regardless of REQ.
  - REQ may stay high after GNT; it is treated as a new request on the next IDLE.
- Simultaneous requests: only the winner is served; the others wait and are reconsidered on the next IDLE.
- Reset mid-operation: RST asserted in DRIVE or SETTLE returns the block to IDLE with all outputs 0 at the next edge and PTR=0. The flag bank resets in the same cycle, so the in-flight strobe is superseded. Pending requesters must re-request.

Test Plan:
- Reset: hold RST for 2 cycles with REQ=1111 -> S=R=0, GNT=0, BUSY=0. The first grant after release goes to requester 0.
- Single SET: REQ[2]=1, OP=10, IDX=5 in IDLE -> next cycle GNT=0100, S=6'b100000, R=0, RDATA=0; Q[5]=1 one cycle later; BUSY high for 2 cycles.
- Round-robin: REQ=1111 held, all READ -> GNT sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- TAS contention: req0 and req1 both TAS on IDX=2 with Q[2]=0 -> req0 granted with RDATA=0; req1 granted 3 cycles later with RDATA=1; S[2] pulses twice; R stays 0.
- CLR then error: req3 CLR IDX=2 -> R[2] pulse and Q[2]=0. Then req3 SET IDX=7 -> GNT=1000, ERR=1, S=R=0, Q unchanged.
- RST asserted during DRIVE of a SET -> next cycle all outputs 0, state IDLE, flag bank cleared.
- Bench assertion, checked continuously on every run: (S&R)==0, GNT one-hot-or-zero.
